// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI reader.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Command word sent MSB first: start bit, single-ended bit, 3-bit channel.
    localparam logic CMD_START    = 1'b1;
    localparam logic CMD_SGL      = 1'b1;
    localparam int   CMD_BITS     = 5;

    // Leading ad_sclk periods whose ad_dout bits are not part of the result
    // (command, sample and null bit).
    localparam int   DISCARD_BITS = 7;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator for the ADC SPI reader.
// Produces ad_sclk (idle low) as CLK_DIV cycles low then CLK_DIV cycles high
// per period while enable is high, and counts periods starting at 1.
// low_first is high on the cycle whose closing edge starts a low half, so a
// register loaded on it changes exactly on the first low cycle.
// high_last is high during the last high cycle itself, so a register loaded
// on it samples at the end of the high half.
module adc_sclk_gen #(
    parameter int CLK_DIV = 4,
    parameter int PER_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             ad_sclk,
    output logic             low_first,
    output logic             high_last,
    output logic [PER_W-1:0] period
);

    localparam logic [7:0] DIV_TOP = 8'(CLK_DIV - 1);

    logic [7:0]       cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             run_q, run_d;
    logic [PER_W-1:0] per_q, per_d;

    // Next half-period count, phase and period number.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        per_d  = per_q;
        run_d  = enable;
        if (!enable) begin
            cnt_d  = DIV_TOP;
            sclk_d = 1'b0;
            per_d  = '0;
        end else if (!run_q) begin
            cnt_d  = DIV_TOP;
            sclk_d = 1'b0;
            per_d  = PER_W'(1);
        end else if (cnt_q == 8'd0) begin
            cnt_d  = DIV_TOP;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                per_d = per_q + PER_W'(1);
            end
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Generator state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= DIV_TOP;
            sclk_q <= 1'b0;
            run_q  <= 1'b0;
            per_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            run_q  <= run_d;
            per_q  <= per_d;
        end
    end

    assign ad_sclk   = sclk_q;
    assign period    = per_q;
    assign high_last = run_q & sclk_q & (cnt_q == 8'd0);
    assign low_first = enable & ~sclk_d & (cnt_d == DIV_TOP);

endmodule

// File: rtl/adc_spi_reader.sv
// ADC SPI reader: issues a single-ended conversion command for a latched
// channel and returns the DATA_W-bit result.
// Optional build macro ADC_DOUT_SYNC_EN adds a two-flop synchronizer on ad_dout.
//
// state | meaning
// IDLE  | waiting for start, ad_cs high
// SETUP | ad_cs low, ad_sclk low, CLK_DIV cycles
// SHIFT | 7+DATA_W ad_sclk periods, command out, result in
// HOLD  | ad_sclk low, ad_cs low, CLK_DIV cycles
// GAP   | ad_cs high, busy still high, CLK_DIV cycles
module adc_spi_reader #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12,
    parameter int CH_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   channel,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ad_cs,
    output logic              ad_sclk,
    output logic              ad_din,
    input  logic              ad_dout
);

    import adc_spi_pkg::*;

    localparam int               F         = DISCARD_BITS + DATA_W;
    localparam int               PER_W     = $clog2(F + 1);
    localparam logic [7:0]       DIV_TOP   = 8'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] LAST_PER  = PER_W'(F);
    localparam logic [PER_W-1:0] KEEP_FROM = PER_W'(DISCARD_BITS + 1);

    state_t              state_q, state_d;
    logic [7:0]          timer_q, timer_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                cs_q, cs_d;
    logic                din_q, din_d;

    logic                shift_run;
    logic                low_first;
    logic                high_last;
    logic [PER_W-1:0]    period;
    logic                dout_s;

`ifdef ADC_DOUT_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    assign sync1_d = ad_dout;
    assign sync2_d = sync1_q;

    // Two-flop synchronizer for the converter's result line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign dout_s = sync2_q;
`else
    assign dout_s = ad_dout;
`endif

    // The generator runs whenever the next cycle belongs to SHIFT; this is
    // built only from registered state so it never depends on low_first.
    assign shift_run = ((state_q == SETUP) && (timer_q == 8'd0)) ||
                       ((state_q == SHIFT) && !(high_last && (period == LAST_PER)));

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .PER_W   (PER_W)
    ) u_sclk_gen (
        .clock     (clock),
        .reset     (reset),
        .enable    (shift_run),
        .ad_sclk   (ad_sclk),
        .low_first (low_first),
        .high_last (high_last),
        .period    (period)
    );

    // Next-state and registered-output logic for the conversion sequence.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cmd_d   = cmd_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cs_d    = cs_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    timer_d = DIV_TOP;
                    cmd_d   = {CMD_START, CMD_SGL, 3'(channel)};
                end
            end
            SETUP: begin
                if (timer_q == 8'd0) begin
                    state_d = SHIFT;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            SHIFT: begin
                if (high_last) begin
                    if (period >= KEEP_FROM) begin
                        shreg_d = {shreg_q[DATA_W-2:0], dout_s};
                    end
                    if (period == LAST_PER) begin
                        state_d = HOLD;
                        timer_d = DIV_TOP;
                    end
                end
            end
            HOLD: begin
                if (timer_q == 8'd0) begin
                    state_d = GAP;
                    timer_d = DIV_TOP;
                    cs_d    = 1'b1;
                    valid_d = 1'b1;
                    data_d  = shreg_q;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            GAP: begin
                if (timer_q == 8'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Command bits leave MSB first; zeros follow once the word is spent.
        if (low_first) begin
            din_d = cmd_q[CMD_BITS-1];
            cmd_d = {cmd_q[CMD_BITS-2:0], 1'b0};
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= 8'd0;
            cmd_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cs_q    <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cmd_q   <= cmd_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cs_q    <= cs_d;
            din_q   <= din_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign data   = data_q;
    assign ad_cs  = cs_q;
    assign ad_din = din_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Testbench for adc_spi_reader with a behavioural converter model.
module tb_adc_spi_reader;

`ifdef ADC_DOUT_SYNC_EN
    localparam int D = 3;
    localparam logic [11:0] W0 = 12'h5A3;
`else
    localparam int D = 4;
    localparam logic [11:0] W0 = 12'hA5C;
`endif
    localparam int DW = 12;
    localparam int CW = 2;
    localparam int F  = 7 + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] channel = '0;
    logic          busy, valid;
    logic [DW-1:0] data;
    logic          ad_cs, ad_sclk, ad_din;
    logic          ad_dout = 1'b0;

    adc_spi_reader #(
        .CLK_DIV (D),
        .DATA_W  (DW),
        .CH_W    (CW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .channel (channel),
        .busy    (busy),
        .valid   (valid),
        .data    (data),
        .ad_cs   (ad_cs),
        .ad_sclk (ad_sclk),
        .ad_din  (ad_din),
        .ad_dout (ad_dout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Converter model and bus monitor; the only writer of the record state.
    logic [DW-1:0] cur_word = '0;
    int per = 0, rises = 0, frame = 0, vcount = 0, cs_idx = 0;
    int valid_cyc[$];
    int cs_fall[$];
    int cs_rise[$];
    int busy_fall[$];
    int bad_din = 0, bad_valid = 0, bad_data = 0, bad_sclk = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    logic prev_rst = 1'b1, prev_din = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clock) begin
        #1;
        if (!ad_cs) cs_idx = prev_cs ? 0 : cs_idx + 1;
        if (!reset && !prev_rst) begin
            if (ad_din !== prev_din && !((prev_sclk && !ad_sclk) || (!ad_cs && cs_idx == D)))
                bad_din++;
            if (valid && prev_valid) bad_valid++;
            if (data !== prev_data && !valid) bad_data++;
            if (ad_cs && ad_sclk) bad_sclk++;
        end
        if (prev_cs && !ad_cs) begin
            cs_fall.push_back(cyc);
            per = 1;
        end
        if (!prev_cs && ad_cs) begin
            cs_rise.push_back(cyc);
            per = 0;
        end
        if (!ad_cs && prev_sclk && !ad_sclk) per++;
        if (!ad_cs && !prev_sclk && ad_sclk) begin
            rises++;
            frame = (frame << 1) | int'(ad_din);
        end
        if (valid) begin
            vcount++;
            valid_cyc.push_back(cyc);
        end
        if (prev_busy && !busy) busy_fall.push_back(cyc);
        // Result bit for period p (8..F) is presented from the start of its low half.
        if (per >= 8 && per <= F) ad_dout = cur_word[DW-1-(per-8)];
        else ad_dout = 1'($urandom_range(0, 1));
        prev_cs    = ad_cs;
        prev_sclk  = ad_sclk;
        prev_valid = valid;
        prev_busy  = busy;
        prev_rst   = reset;
        prev_din   = ad_din;
        prev_data  = data;
    end

    function automatic int exp_frame(input int ch);
        // bits 1,1,0,c1,c0 in the first five periods, zeros after
        return ((3 << 3) | ch) << (F - 5);
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clock); #2;
            n++;
        end while (busy !== 1'b0 && n < budget);
        if (busy !== 1'b0) chk("busy_timeout", 1, 0);
    endtask

    task automatic run_frame(input logic [CW-1:0] ch, input logic [DW-1:0] word, input int poke);
        int t, v0, vc0, f0, b0, r0;
        v0 = vcount; vc0 = valid_cyc.size(); f0 = cs_fall.size();
        b0 = busy_fall.size(); r0 = rises;
        cur_word = word;
        @(posedge clock); #2;
        start = 1'b1; channel = ch; t = cyc;
        @(posedge clock); #2;
        start = 1'b0; channel = CW'($urandom);
        if (poke > 0) begin
            repeat (poke) @(posedge clock);
            #2; start = 1'b1; channel = ~ch;
            @(posedge clock); #2; start = 1'b0;
        end
        wait_idle(400);
        repeat (2 * D + 8) @(posedge clock);
        #2;
        chk("valid_count", vcount - v0, 1);
        chk("cs_falls", cs_fall.size() - f0, 1);
        if (valid_cyc.size() > vc0) chk("valid_latency", valid_cyc[vc0] - t, 1 + (2 * F + 2) * D);
        if (busy_fall.size() > b0) chk("busy_latency", busy_fall[b0] - t, 1 + (2 * F + 3) * D);
        chk("data", int'(data), int'(word));
        chk("sclk_periods", rises - r0, F);
        chk("din_frame", frame & ((1 << F) - 1), exp_frame(int'(ch)));
    endtask

    task automatic back_to_back(input logic [CW-1:0] ch, input logic [DW-1:0] word);
        int n, v0, vc0, f0, r0, c0;
        v0 = vcount; vc0 = valid_cyc.size(); f0 = cs_fall.size();
        r0 = rises; c0 = cs_rise.size();
        n = 0;
        cur_word = word;
        @(posedge clock); #2;
        start = 1'b1; channel = ch;
        while (vcount - v0 < 2 && n < 800) begin
            @(posedge clock); #2;
            n++;
        end
        start = 1'b0;
        if (vcount - v0 < 2) chk("b2b_timeout", 1, 0);
        wait_idle(100);
        repeat (2 * D + 8) @(posedge clock);
        #2;
        chk("b2b_valids", vcount - v0, 2);
        chk("b2b_cs_falls", cs_fall.size() - f0, 2);
        if (cs_fall.size() >= f0 + 2 && cs_rise.size() > c0)
            chk("b2b_cs_gap", cs_fall[f0 + 1] - cs_rise[c0], D + 1);
        if (valid_cyc.size() >= vc0 + 2 && cs_fall.size() >= f0 + 2)
            chk("b2b_latency2", valid_cyc[vc0 + 1] - cs_fall[f0 + 1], (2 * F + 2) * D);
        chk("b2b_data", int'(data), int'(word));
        chk("b2b_sclk_periods", rises - r0, 2 * F);
    endtask

    task automatic reset_mid_frame();
        int v0, f0;
        v0 = vcount; f0 = cs_fall.size();
        cur_word = DW'($urandom);
        @(posedge clock); #2;
        start = 1'b1; channel = CW'($urandom);
        @(posedge clock); #2;
        start = 1'b0;
        // period 10 begins 1+D+18*D cycles after acceptance; land two cycles into it
        repeat (D + 18 * D + 2) @(posedge clock);
        #2; reset = 1'b1;
        #1;
        chk("rst_cs", int'(ad_cs), 1);
        chk("rst_sclk", int'(ad_sclk), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_din", int'(ad_din), 0);
        @(posedge clock); #2; reset = 1'b0;
        repeat (300) @(posedge clock);
        #2;
        chk("rst_no_valid", vcount - v0, 0);
        chk("rst_no_restart", cs_fall.size() - f0, 1);
        chk("rst_data_held", int'(data), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held together with start must win
        reset = 1'b1; start = 1'b1; channel = 2'd3;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_cs", int'(ad_cs), 1);
        chk("reset_sclk", int'(ad_sclk), 0);
        chk("reset_din", int'(ad_din), 0);
        reset = 1'b0; start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        chk("idle_cs", int'(ad_cs), 1);

        run_frame(2'd2, W0, 0);
        run_frame(2'd1, 12'h000, 0);
        run_frame(2'd3, 12'hFFF, 0);
        for (int i = 0; i < 4; i++) run_frame(CW'($urandom), DW'($urandom), 0);
        run_frame(CW'($urandom), DW'($urandom), 40);
        back_to_back(2'd0, 12'h3C9);
        run_frame(2'd1, 12'h5A5, 0);
        reset_mid_frame();

        chk("din_timing_violations", bad_din, 0);
        chk("valid_wide_pulses", bad_valid, 0);
        chk("data_changes_outside_valid", bad_data, 0);
        chk("sclk_with_cs_high", bad_sclk, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving clock cycles per ad_sclk half-period (legal 2..255; 3..255 when ADC_DOUT_SYNC_EN is defined).
REQ-002 SHALL have parameter DATA_W, default 12, giving converter result width.
REQ-003 SHALL have parameter CH_W, default 2, giving channel-select width (legal 1..3).
REQ-004 clock  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  conversion request, sampled only while busy=0.
REQ-007 channel  in  CH_W  channel number, latched on an accepted start.
REQ-008 busy  out  1  high from accepted start until gap expires.
REQ-009 valid  out  1  one-cycle pulse when data is updated.
REQ-010 data  out  DATA_W  last conversion result, held between conversions.
REQ-011 ad_cs  out  1  converter chip select, active-low.
REQ-012 ad_sclk  out  1  serial clock, idle low.
REQ-013 ad_din  out  1  command bits to converter.
REQ-014 ad_dout  in  1  result bits from converter.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-016 In IDLE, start=1 SHALL latch channel, set busy=1, drive ad_cs=0 the next cycle, and enter SETUP; start while busy=1 SHALL be ignored, with no queueing.
REQ-017 SETUP SHALL last CLK_DIV cycles, with ad_cs=0 and ad_sclk=0.
REQ-018 SHIFT SHALL run F = 7+DATA_W ad_sclk periods, each with CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 ad_din SHALL change only on the first cycle of each low half.
- Command bits, MSB first: 1 (start), 1 (single-ended), then channel zero-extended to 3 bits.
- ad_din=0 for all remaining periods.
REQ-020 ad_dout SHALL be sampled on the last cycle of each high half.
- Periods 1..7 (command, sample, null) SHALL be discarded.
- Periods 8..F SHALL shift into a DATA_W register, MSB first.
REQ-021 HOLD SHALL last CLK_DIV cycles, with ad_sclk=0 and ad_cs=0.
REQ-022 At HOLD end, in one cycle: ad_cs=1, data updated, valid=1; then enter GAP.
REQ-023 GAP SHALL last CLK_DIV cycles, with ad_cs=1; busy SHALL fall when GAP ends.
REQ-024 Latency SHALL be: valid at T+1+(2F+2)*CLK_DIV for start accepted at cycle T; busy low CLK_DIV cycles later.
REQ-025 start asserted on the cycle busy falls SHALL be ignored; it is accepted the following cycle if still high.
REQ-026 data SHALL not change except at REQ-022; valid SHALL never exceed one cycle.

Reset
REQ-027 reset SHALL force, immediately and asynchronously: IDLE, ad_cs=1, ad_sclk=0, ad_din=0, busy=0, valid=0, data=0.
REQ-028 Reset mid-frame SHALL abort the frame with no valid pulse; reset and start together SHALL yield reset.

Configuration
REQ-029 With ADC_DOUT_SYNC_EN defined:
- ad_dout SHALL pass through a two-flop synchronizer reset to 0.
- The synchronized value SHALL be sampled at the REQ-020 point.
REQ-030 Without ADC_DOUT_SYNC_EN, raw ad_dout SHALL be sampled at the REQ-020 point; timing is otherwise identical.

Structure
REQ-031 Package adc_spi_pkg SHALL hold:
- the state enum type;
- constants CMD_START=1, CMD_SGL=1, CMD_BITS=5 and DISCARD_BITS=7.
REQ-032 Sub-module adc_sclk_gen SHALL provide:
- the CLK_DIV half-period counter;
- ad_sclk;
- one-cycle strobes low_first and high_last;
- enable in, and a period counter out.

Verification
REQ-033 CLK_DIV=4, channel=2, model returns 0xA5C -> ad_din frame 1,1,0,1,0; data=0xA5C; valid at T+161; busy low at T+165.
REQ-034 Back-to-back starts held high -> second ad_cs fall exactly CLK_DIV+1 cycles after first ad_cs rise; no overlap.
REQ-035 start pulsed while busy, mid-SHIFT -> ignored; exactly one valid; ad_din frame unchanged.
REQ-036 reset asserted at SHIFT period 10 -> ad_cs=1 and ad_sclk=0 same cycle; no valid; previous data cleared to 0.
REQ-037 Model returns 0x000, then 0xFFF -> data 0x000, then 0xFFF; no bit-order or off-by-one error.
REQ-038 ADC_DOUT_SYNC_EN defined, CLK_DIV=3, model returns 0x5A3 -> data=0x5A3; latency same as REQ-024.
